fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/cpu_types_pkg.sv | 53 +++++
 rtl/pc_if.sv | 30 +++
 rtl/fetch_ctrl_redirect_buf.sv | 30 +++
 rtl/fetch_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared CPU types: word, fetch states, pcsrc and redirect kinds.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PCSRC_PC4  = 2'd0,
        PCSRC_BR   = 2'd1,
        PCSRC_JR   = 2'd2,
        PCSRC_JIMM = 2'd3
    } pcsrc_t;

    typedef enum logic [1:0] {
        KIND_BR   = 2'd0,
        KIND_JR   = 2'd1,
        KIND_J    = 2'd2,
        KIND_RSVD = 2'd3
    } rd_kind_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic        beq;
        logic        zero;
        word_t       immedEXT;
        word_t       rdat1;
        logic [15:0] immed;
        word_t       pc4;
    } redirect_t;

    function automatic logic [1:0] kind_to_pcsrc(input logic [1:0] kind);
        logic [1:0] sel;
        case (kind)
            KIND_BR: sel = PCSRC_BR;
            KIND_JR: sel = PCSRC_JR;
            KIND_J:  sel = PCSRC_JIMM;
            default: sel = PCSRC_PC4;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_if
// Brief    : Input side of the PC register; fetch control drives it via tb.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_if;
    import cpu_types_pkg::*;

    logic        pcenable;
    logic [1:0]  pcsrc;
    logic        branch;
    logic        BEQ;
    logic        zero_f;
    word_t       immedEXT;
    word_t       rdat1;
    logic [15:0] immed;
    word_t       branch_pc4;

    modport pc (
        input pcenable, pcsrc, branch, BEQ, zero_f,
              immedEXT, rdat1, immed, branch_pc4
    );

    modport tb (
        output pcenable, pcsrc, branch, BEQ, zero_f,
               immedEXT, rdat1, immed, branch_pc4
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl_redirect_buf.sv
`default_nettype none
// ============================================================================
// Module   : redirect_buf
// Brief    : Holds the operands of the most recent redirect seen in RUN.
// Revision : 1.0 - initial release
// ============================================================================
module redirect_buf
    import cpu_types_pkg::*;
(
    input  logic      CLK,
    input  logic      nRST,
    input  logic      load,
    input  redirect_t d,
    output redirect_t q
);

    redirect_t r_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Fetch FSM: applies or defers EX redirects, handles stall/halt.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        stall,
    input  logic        halt,
    input  logic        rd_valid,
    input  logic [1:0]  rd_kind,
    input  logic        rd_beq,
    input  logic        rd_zero,
    input  word_t       rd_immedEXT,
    input  word_t       rd_rdat1,
    input  logic [15:0] rd_immed,
    input  word_t       rd_pc4,
    input  word_t       pcout,
    pc_if.tb            pcif,
    output logic        iREN,
    output word_t       imemaddr,
    output logic        flush,
    output logic        halted
);

    fetch_state_t r_state;
    fetch_state_t w_next;

    redirect_t w_live;
    redirect_t w_held;
    redirect_t w_ops;
    logic      w_redirect;
    logic      w_buf_load;
    logic      w_pcenable;
    logic      w_flush;
    logic      w_branch;
    logic [1:0] w_pcsrc;

    always_comb begin
        w_live          = '0;
        w_live.kind     = rd_kind;
        w_live.beq      = rd_beq;
        w_live.zero     = rd_zero;
        w_live.immedEXT = rd_immedEXT;
        w_live.rdat1    = rd_rdat1;
        w_live.immed    = rd_immed;
        w_live.pc4      = rd_pc4;
    end

    // The reserved kind never redirects.
    assign w_redirect = rd_valid && (rd_kind != KIND_RSVD);

    // Loading on every RUN redirect also keeps the operands stable afterwards.
    assign w_buf_load = (r_state == RUN) && w_redirect && !halt;

    redirect_buf u_buf (
        .CLK  (CLK),
        .nRST (nRST),
        .load (w_buf_load),
        .d    (w_live),
        .q    (w_held)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN: begin
                if (halt) begin
                    w_next = HALTED;
                end else if (w_redirect && !ihit) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                if (halt) begin
                    w_next = HALTED;
                end else if (ihit) begin
                    w_next = RUN;
                end
            end
            HALTED:  w_next = HALTED;
            default: w_next = RUN;
        endcase
    end

    always_comb begin
        w_pcenable = 1'b0;
        w_flush    = 1'b0;
        w_branch   = 1'b0;
        w_pcsrc    = PCSRC_PC4;
        w_ops      = w_held;
        case (r_state)
            RUN: begin
                if (!halt) begin
                    if (w_redirect) begin
                        w_ops = w_live;
                        if (ihit) begin
                            w_pcenable = 1'b1;
                            w_flush    = 1'b1;
                            w_pcsrc    = kind_to_pcsrc(rd_kind);
                            w_branch   = (rd_kind == KIND_BR);
                        end
                    end else begin
                        w_pcenable = ihit && !stall;
                    end
                end
            end
            HOLD: begin
                if (!halt) begin
                    w_pcsrc  = kind_to_pcsrc(w_held.kind);
                    w_branch = (w_held.kind == KIND_BR);
                    if (ihit) begin
                        w_pcenable = 1'b1;
                        w_flush    = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
        // Reset must silence the PC controls immediately, not at the next edge.
        if (!nRST) begin
            w_pcenable = 1'b0;
            w_flush    = 1'b0;
            w_branch   = 1'b0;
            w_pcsrc    = PCSRC_PC4;
            w_ops      = w_held;
        end
    end

    assign pcif.pcenable   = w_pcenable;
    assign pcif.pcsrc      = w_pcsrc;
    assign pcif.branch     = w_branch;
    assign pcif.BEQ        = w_ops.beq;
    assign pcif.zero_f     = w_ops.zero;
    assign pcif.immedEXT   = w_ops.immedEXT;
    assign pcif.rdat1      = w_ops.rdat1;
    assign pcif.immed      = w_ops.immed;
    assign pcif.branch_pc4 = w_ops.pc4;

    assign flush    = w_flush;
    assign halted   = (r_state == HALTED);
    assign iREN     = (r_state != HALTED);
    assign imemaddr = pcout;

endmodule
`default_nettype wire
